// File: rtl/exec_controller_pkg.sv
// Shared definitions for the exec_controller slice: opcodes, instruction field
// positions, FSM state encodings and an opcode classifier.
package exec_controller_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_MUL  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_LDI  = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 9;
  localparam int RS1_HI = 8;
  localparam int RS1_LO = 6;
  localparam int RS2_HI = 5;
  localparam int RS2_LO = 3;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_DECODE    = 3'd2;
  localparam logic [2:0] S_EXECUTE   = 3'd3;
  localparam logic [2:0] S_WRITEBACK = 3'd4;
  localparam logic [2:0] S_HALTED    = 3'd5;

  typedef enum logic [1:0] {
    CLS_NOP,
    CLS_ALU,
    CLS_LDI,
    CLS_HALT
  } instr_class_e;

  // Undefined opcodes fall through to NOP
  function automatic instr_class_e classify(input logic [3:0] opcode);
    case (opcode)
      OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR: return CLS_ALU;
      OP_LDI:  return CLS_LDI;
      OP_HALT: return CLS_HALT;
      default: return CLS_NOP;
    endcase
  endfunction

endpackage

// File: rtl/exec_controller_alu.sv
// Combinational ALU: add/sub with carry/borrow, low-half multiply and bitwise ops.
module exec_controller_alu
  import exec_controller_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);

  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] prod;

  // The extra top bit of diff is the borrow, set exactly when a < b
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  assign prod = a * b;

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      OP_SUB: begin
        result = diff[DATA_W-1:0];
        carry  = diff[DATA_W];
      end
      OP_MUL:  result = prod;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/exec_controller.sv
// Fetch/decode/execute/writeback sequencer for the 8-register, 8-bit processor.
// Owns pc, IR, operand, result and flag registers; the register file is external.
module exec_controller
  import exec_controller_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int REG_AW  = 3,
  parameter int PC_W    = 4,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instr,
  output logic [REG_AW-1:0]  rf_rd_addr1,
  output logic [REG_AW-1:0]  rf_rd_addr2,
  input  logic [DATA_W-1:0]  rf_rd_data1,
  input  logic [DATA_W-1:0]  rf_rd_data2,
  output logic               rf_we,
  output logic [REG_AW-1:0]  rf_wr_addr,
  output logic [DATA_W-1:0]  rf_wr_data,
  output logic               busy,
  output logic               halted,
  output logic               zero_flag,
  output logic               carry_flag
);

  logic [2:0]         state;
  logic [PC_W-1:0]    pc_q;
  logic [INSTR_W-1:0] ir;
  logic [DATA_W-1:0]  op_a;
  logic [DATA_W-1:0]  op_b;
  logic [DATA_W-1:0]  result_q;
  logic               carry_q;
  logic               zero_q;

  logic [3:0]         opcode;
  instr_class_e       cls;
  logic [DATA_W-1:0]  alu_result;
  logic               alu_carry;
  logic               alu_zero;

  assign opcode = ir[OPC_HI:OPC_LO];
  assign cls    = classify(opcode);

  exec_controller_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (opcode),
    .a      (op_a),
    .b      (op_b),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  // LDI loads the immediate and deliberately leaves both flags alone
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      pc_q     <= '0;
      ir       <= '0;
      op_a     <= '0;
      op_b     <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) state <= S_FETCH;
        end
        S_FETCH: begin
          ir    <= instr;
          state <= S_DECODE;
        end
        S_DECODE: begin
          op_a <= rf_rd_data1;
          op_b <= rf_rd_data2;
          case (cls)
            CLS_NOP: begin
              pc_q  <= pc_q + PC_W'(1);
              state <= S_FETCH;
            end
            CLS_HALT: state <= S_HALTED;
            default:  state <= S_EXECUTE;
          endcase
        end
        S_EXECUTE: begin
          if (cls == CLS_LDI) begin
            result_q <= ir[IMM_HI:IMM_LO];
          end else begin
            result_q <= alu_result;
            carry_q  <= alu_carry;
            zero_q   <= alu_zero;
          end
          state <= S_WRITEBACK;
        end
        S_WRITEBACK: begin
          pc_q  <= pc_q + PC_W'(1);
          state <= S_FETCH;
        end
        S_HALTED: state <= S_HALTED;
        default:  state <= S_IDLE;
      endcase
    end
  end

  logic addr_active;
  logic in_wb;

  assign addr_active = (state == S_DECODE) || (state == S_EXECUTE) || (state == S_WRITEBACK);
  assign in_wb       = (state == S_WRITEBACK);

  assign pc          = pc_q;
  assign busy        = (state == S_FETCH) || addr_active;
  assign halted      = (state == S_HALTED);
  assign zero_flag   = zero_q;
  assign carry_flag  = carry_q;
  assign rf_rd_addr1 = addr_active ? ir[RS1_HI:RS1_LO] : '0;
  assign rf_rd_addr2 = addr_active ? ir[RS2_HI:RS2_LO] : '0;
  // Gating with rst drops a write that coincides with reset
  assign rf_we       = in_wb && !rst;
  assign rf_wr_addr  = in_wb ? ir[RD_HI:RD_LO] : '0;
  assign rf_wr_data  = in_wb ? result_q : '0;

endmodule

// File: tb/tb_exec_controller.sv
// Bench for exec_controller: instruction ROM plus register-file model,
// table of single-op programs and hand-written multi-cycle sequences.
module tb_exec_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  pc;
  logic [15:0] instr;
  logic [2:0]  rf_rd_addr1;
  logic [2:0]  rf_rd_addr2;
  logic [7:0]  rf_rd_data1;
  logic [7:0]  rf_rd_data2;
  logic        rf_we;
  logic [2:0]  rf_wr_addr;
  logic [7:0]  rf_wr_data;
  logic        busy;
  logic        halted;
  logic        zero_flag;
  logic        carry_flag;

  logic [15:0] rom [16];
  logic [7:0]  regs [8];
  logic        rf_clear;
  int          we_count;
  int          n_compared;
  int          n_mismatched;

  always #5 clk = ~clk;

  exec_controller dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .pc          (pc),
    .instr       (instr),
    .rf_rd_addr1 (rf_rd_addr1),
    .rf_rd_addr2 (rf_rd_addr2),
    .rf_rd_data1 (rf_rd_data1),
    .rf_rd_data2 (rf_rd_data2),
    .rf_we       (rf_we),
    .rf_wr_addr  (rf_wr_addr),
    .rf_wr_data  (rf_wr_data),
    .busy        (busy),
    .halted      (halted),
    .zero_flag   (zero_flag),
    .carry_flag  (carry_flag)
  );

  // ROM and register file: combinational reads, register file written on the clock edge
  assign instr       = rom[pc];
  assign rf_rd_data1 = regs[rf_rd_addr1];
  assign rf_rd_data2 = regs[rf_rd_addr2];

  always @(posedge clk) begin
    if (rf_clear) begin
      for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
    end else if (rf_we) begin
      regs[rf_wr_addr] <= rf_wr_data;
    end
    if (rf_we) we_count <= we_count + 1;
  end

  typedef struct {
    logic [3:0] op;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       c;
    logic       z;
  } vec_t;

  vec_t vecs [13];

  function automatic logic [15:0] enc_alu(input logic [3:0] op, input logic [2:0] rd,
                                          input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, rd, rs1, rs2, 3'b000};
  endfunction

  function automatic logic [15:0] enc_ldi(input logic [2:0] rd, input logic [7:0] imm);
    return {4'h7, rd, 1'b0, imm};
  endfunction

  localparam logic [15:0] I_NOP  = 16'h0000;
  localparam logic [15:0] I_HALT = 16'hF000;

  task automatic check_output(input string name, input int actual, input int expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic apply_reset();
    rst      = 1'b1;
    rf_clear = 1'b1;
    start    = 1'b0;
    repeat (2) @(negedge clk);
    rst      = 1'b0;
    rf_clear = 1'b0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = I_NOP;
  endtask

  // Cycle count is the number of clock edges after the edge that sampled start
  task automatic apply_stimulus(input int max_cycles, output int cycles);
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    cycles = 0;
    while (!halted && cycles < max_cycles) begin
      @(negedge clk);
      cycles++;
    end
    check_output("halted_reached", int'(halted), 1);
  endtask

  initial begin
    int cycles;
    int we0;
    int max_pc;
    bit found;

    n_compared   = 0;
    n_mismatched = 0;

    vecs[0]  = '{4'h1, 3'd2, 3'd0, 3'd1, 8'd5,   8'd3,   8'd8,   1'b0, 1'b0};
    vecs[1]  = '{4'h1, 3'd3, 3'd0, 3'd1, 8'd200, 8'd100, 8'd44,  1'b1, 1'b0};
    vecs[2]  = '{4'h2, 3'd4, 3'd1, 3'd0, 8'd100, 8'd200, 8'd156, 1'b1, 1'b0};
    vecs[3]  = '{4'h2, 3'd5, 3'd0, 3'd0, 8'd200, 8'd200, 8'd0,   1'b0, 1'b1};
    vecs[4]  = '{4'h3, 3'd2, 3'd0, 3'd1, 8'd16,  8'd17,  8'h10,  1'b0, 1'b0};
    vecs[5]  = '{4'h4, 3'd3, 3'd0, 3'd1, 8'hF0,  8'h3C,  8'h30,  1'b0, 1'b0};
    vecs[6]  = '{4'h5, 3'd3, 3'd0, 3'd1, 8'hF0,  8'h3C,  8'hFC,  1'b0, 1'b0};
    vecs[7]  = '{4'h6, 3'd3, 3'd0, 3'd1, 8'hF0,  8'h3C,  8'hCC,  1'b0, 1'b0};
    vecs[8]  = '{4'h1, 3'd1, 3'd1, 3'd1, 8'd7,   8'd7,   8'd14,  1'b0, 1'b0};
    vecs[9]  = '{4'h1, 3'd2, 3'd0, 3'd1, 8'h80,  8'h80,  8'h00,  1'b1, 1'b1};
    vecs[10] = '{4'h2, 3'd6, 3'd2, 3'd3, 8'd5,   8'd3,   8'd2,   1'b0, 1'b0};
    vecs[11] = '{4'h3, 3'd7, 3'd4, 3'd5, 8'd0,   8'd9,   8'd0,   1'b0, 1'b1};
    vecs[12] = '{4'h6, 3'd1, 3'd3, 3'd4, 8'h55,  8'h55,  8'h00,  1'b0, 1'b1};

    clear_rom();
    apply_reset();
    check_output("reset_pc",     int'(pc), 0);
    check_output("reset_busy",   int'(busy), 0);
    check_output("reset_halted", int'(halted), 0);
    check_output("reset_we",     int'(rf_we), 0);
    check_output("reset_carry",  int'(carry_flag), 0);
    check_output("reset_zero",   int'(zero_flag), 0);
    check_output("reset_rdaddr", int'(rf_rd_addr1), 0);

    // LDI rs1,a ; LDI rs2,b ; op rd,rs1,rs2 ; HALT
    for (int i = 0; i < 13; i++) begin
      apply_reset();
      clear_rom();
      rom[0] = enc_ldi(vecs[i].rs1, vecs[i].a);
      rom[1] = enc_ldi(vecs[i].rs2, vecs[i].b);
      rom[2] = enc_alu(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2);
      rom[3] = I_HALT;
      we0 = we_count;
      apply_stimulus(60, cycles);
      check_output($sformatf("v%0d_result", i), int'(regs[vecs[i].rd]), int'(vecs[i].res));
      check_output($sformatf("v%0d_carry", i),  int'(carry_flag), int'(vecs[i].c));
      check_output($sformatf("v%0d_zero", i),   int'(zero_flag), int'(vecs[i].z));
      check_output($sformatf("v%0d_cycles", i), cycles, 14);
      check_output($sformatf("v%0d_we", i),     we_count - we0, 3);
    end

    // ADD sets carry, NOP writes nothing, LDI 0 must not touch either flag
    apply_reset();
    clear_rom();
    rom[0] = enc_ldi(3'd0, 8'd200);
    rom[1] = enc_ldi(3'd1, 8'd100);
    rom[2] = enc_alu(4'h1, 3'd3, 3'd0, 3'd1);
    rom[3] = I_NOP;
    rom[4] = enc_ldi(3'd5, 8'd0);
    rom[5] = I_HALT;
    we0 = we_count;
    apply_stimulus(80, cycles);
    check_output("seqA_r3",     int'(regs[3]), 44);
    check_output("seqA_r5",     int'(regs[5]), 0);
    check_output("seqA_carry",  int'(carry_flag), 1);
    check_output("seqA_zero",   int'(zero_flag), 0);
    check_output("seqA_cycles", cycles, 20);
    check_output("seqA_we",     we_count - we0, 4);
    check_output("seqA_pc",     int'(pc), 5);

    // AND after a carrying ADD must clear carry
    apply_reset();
    clear_rom();
    rom[0] = enc_ldi(3'd0, 8'h80);
    rom[1] = enc_ldi(3'd1, 8'h80);
    rom[2] = enc_alu(4'h1, 3'd2, 3'd0, 3'd1);
    rom[3] = enc_alu(4'h4, 3'd3, 3'd0, 3'd1);
    rom[4] = I_HALT;
    apply_stimulus(80, cycles);
    check_output("seqB_r2",     int'(regs[2]), 0);
    check_output("seqB_r3",     int'(regs[3]), 8'h80);
    check_output("seqB_carry",  int'(carry_flag), 0);
    check_output("seqB_zero",   int'(zero_flag), 0);
    check_output("seqB_cycles", cycles, 18);

    // 16 NOPs wrap pc to 0 where a HALT now waits; start pulses while busy are ignored
    apply_reset();
    clear_rom();
    we0    = we_count;
    max_pc = 0;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    cycles = 0;
    while (!halted && cycles < 100) begin
      @(negedge clk);
      cycles++;
      if (pc == 4'd1) rom[0] = I_HALT;
      if (int'(pc) > max_pc) max_pc = int'(pc);
      start = (cycles == 10 || cycles == 25);
    end
    start = 1'b0;
    check_output("wrap_halted", int'(halted), 1);
    check_output("wrap_cycles", cycles, 34);
    check_output("wrap_max_pc", max_pc, 15);
    check_output("wrap_pc",     int'(pc), 0);
    check_output("wrap_we",     we_count - we0, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_output("halt_sticky", int'(halted), 1);
    check_output("halt_busy",   int'(busy), 0);
    check_output("halt_pc",     int'(pc), 0);

    // Reset during the ADD writeback must drop the write
    apply_reset();
    clear_rom();
    rom[0] = enc_ldi(3'd0, 8'd200);
    rom[1] = enc_ldi(3'd1, 8'd100);
    rom[2] = enc_ldi(3'd2, 8'h77);
    rom[3] = enc_alu(4'h1, 3'd2, 3'd0, 3'd1);
    rom[4] = I_HALT;
    we0   = we_count;
    found = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (rf_we && rf_wr_addr == 3'd2 && rf_wr_data == 8'd44) found = 1'b1;
      else @(negedge clk);
    end
    check_output("rstwb_reached", int'(found), 1);
    check_output("rstwb_carry_before", int'(carry_flag), 1);
    rst = 1'b1;
    @(negedge clk);
    check_output("rstwb_we",     int'(rf_we), 0);
    rst = 1'b0;
    check_output("rstwb_r2",     int'(regs[2]), 8'h77);
    check_output("rstwb_busy",   int'(busy), 0);
    check_output("rstwb_halted", int'(halted), 0);
    check_output("rstwb_pc",     int'(pc), 0);
    check_output("rstwb_carry",  int'(carry_flag), 0);
    check_output("rstwb_zero",   int'(zero_flag), 0);
    check_output("rstwb_wecount", we_count - we0, 3);
    @(negedge clk);
    check_output("rstwb_idle",   int'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
